mvm_frame_driver: RTL and testbench
===================================

// Module: mvm_frame_driver
// PURPOSE
//  Hardware stream source/sink for the mvm3 matrix-vector core: the transmitting end of its
//  s_valid/s_ready input port and the receiving end of its m_valid/m_ready output port.
//  Replays FRAMES preloaded frames (N*N matrix + N vector + N bias bytes each) into the core.
//  Captures the N 16-bit results of each frame into a readable result buffer.
//  Sits beside the core in the on-chip self-test wrapper, in place of the simulation stimulus.
// PARAMETERS
//  N       3   matrix dimension; frame length TOTAL = N*N + 2*N bytes
//  FRAMES  5   frames per run; stimulus memory FRAMES*TOTAL bytes, result buffer FRAMES*N words
//  DW_IN   8   byte width sent to the core (signed, passed through unmodified)
//  DW_OUT  16  result width received from the core
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  start      in   1       pulse; begins a run when idle
//  ld_we      in   1       stimulus memory write enable
//  ld_addr    in   $clog2(FRAMES*TOTAL)  stimulus byte address
//  ld_data    in   DW_IN   stimulus byte
//  s_valid    out  1       to core s_valid
//  s_ready    in   1       from core s_ready
//  data_out   out  DW_IN   to core data_in
//  m_valid    in   1       from core m_valid
//  m_ready    out  1       to core m_ready
//  data_in    in   DW_OUT  from core data_out
//  rx_hold    in   1       when 1, forces m_ready low (sink backpressure injection)
//  res_addr   in   $clog2(FRAMES*N)      result buffer read address
//  res_data   out  DW_OUT  result buffer word, combinational read
//  busy       out  1       run in progress
//  done       out  1       one-cycle pulse at end of run
//  err        out  1       sticky protocol error
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE; s_valid, m_ready, busy, done, err = 0; data_out = 0.
//   All counters = 0. Stimulus memory and result buffer are not cleared.
//  FSM: IDLE -> SEND -> RECV -> (SEND | FIN) ; FIN -> IDLE.
//   IDLE: start=1 at edge t -> SEND. frame_cnt=byte_cnt=0, busy=1 after t.
//    s_valid=1 after t, with data_out = mem[0].
//   SEND: data_out = mem[frame_cnt*TOTAL + byte_cnt], registered.
//    s_valid stays 1 and data_out is held stable until s_valid&&s_ready.
//    Each acceptance advances byte_cnt. With s_ready held 1, one byte is sent per cycle.
//    Accepting byte TOTAL-1: s_valid=0 next cycle, state -> RECV, res_cnt=0.
//   RECV: m_ready = !rx_hold (registered-free, combinational from state).
//    On m_valid&&m_ready: buf[frame_cnt*N + res_cnt] <= data_in; res_cnt++.
//    Accepting result N-1: if frame_cnt==FRAMES-1, go to FIN; else frame_cnt++, byte_cnt=0,
//     go to SEND, and s_valid=1 the next cycle.
//   FIN: done=1 for exactly one cycle; busy=0 from the following cycle; -> IDLE.
//  Frames are strictly serialized: no byte of frame f+1 is sent before result N-1 of frame f.
//  m_ready=0 in every state except RECV. s_valid=0 in every state except SEND.
//  start while busy: ignored. ld_we while busy: write dropped. ld_we in IDLE: 1-cycle write.
//  err set (sticky until reset) when either condition holds:
//   m_valid=1 in SEND or IDLE (unsolicited result);
//   a run of more than 4096 consecutive cycles in SEND/RECV without a handshake (timeout).
//   On timeout the FSM also goes to FIN.
//  Counters wrap only at their terminal values above; no arithmetic on data (pure transport).
//  reset_n asserted mid-run: outputs drop immediately; partially captured results remain in buf.
// TESTING
//  1. Preload frame0 = 01..0F, s_ready=1, start -> data_out 01..0F on 15 consecutive cycles,
//     s_valid=0 on the next cycle; m_ready=1 next.
//  2. Core model returns 0012, 001B, 0024 for frame0 ->
//     res_addr 0/1/2 read 0012/001B/0024.
//  3. Random s_ready/rx_hold (50%), FRAMES=5 ->
//     75 bytes sent in order, no byte duplicated or dropped;
//     data_out stable while stalled; 15 results match model; done pulses once.
//  4. start asserted again mid-run and ld_we mid-run ->
//     no restart; memory unchanged (readback after done).
//  5. m_valid pulsed during SEND -> err=1 and stays 1 until reset_n; run completes.
//  6. reset_n=0 in RECV of frame 2 -> s_valid=m_ready=busy=0 at once;
//     a new start replays from frame0 byte0.

Source files
------------

// File: rtl/mvm_frame_driver.sv
// mvm_frame_driver: replays preloaded frames into the mvm3 core and captures its results
module mvm_frame_driver #(
    parameter int N = 3,
    parameter int FRAMES = 5,
    parameter int DW_IN = 8,
    parameter int DW_OUT = 16,
    localparam int TOTAL = N * N + 2 * N,
    localparam int AW = $clog2(FRAMES * TOTAL),
    localparam int RW = $clog2(FRAMES * N)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              ld_we,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DW_IN-1:0]  ld_data,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [DW_IN-1:0]  data_out,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [DW_OUT-1:0] data_in,
    input  logic              rx_hold,
    input  logic [RW-1:0]     res_addr,
    output logic [DW_OUT-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int FW = $clog2(FRAMES + 1);
    localparam int BW = $clog2(TOTAL + 1);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, FIN} state_t;

    state_t            state, state_n;
    logic [FW-1:0]     frame_cnt, frame_n;
    logic [BW-1:0]     byte_cnt, byte_n;
    logic [CW-1:0]     res_cnt, res_n;
    logic [12:0]       wait_cnt;
    logic [DW_IN-1:0]  stim_mem [FRAMES*TOTAL];
    logic [DW_OUT-1:0] res_buf [FRAMES*N];
    logic              s_hs, m_hs, active, timeout;
    logic [AW-1:0]     rd_addr;

    assign s_valid  = state == SEND;
    assign m_ready  = state == RECV && !rx_hold;
    assign busy     = state != IDLE;
    assign done     = state == FIN;
    assign s_hs     = s_valid && s_ready;
    assign m_hs     = m_valid && m_ready;
    assign active   = state == SEND || state == RECV;
    assign timeout  = active && !s_hs && !m_hs && wait_cnt == 13'd4096;
    // the byte presented next cycle is addressed by the next-state counters
    assign rd_addr  = AW'(frame_n) * AW'(TOTAL) + AW'(byte_n);
    assign res_data = res_buf[res_addr];

    // next-state and counter sequencing; a stall timeout aborts the run
    always_comb begin
        state_n = state;
        frame_n = frame_cnt;
        byte_n  = byte_cnt;
        res_n   = res_cnt;
        case (state)
            IDLE: if (start) begin
                state_n = SEND;
                frame_n = '0;
                byte_n  = '0;
            end
            SEND: if (s_hs) begin
                if (byte_cnt == BW'(TOTAL - 1)) begin
                    state_n = RECV;
                    res_n   = '0;
                end else begin
                    byte_n = byte_cnt + BW'(1);
                end
            end
            RECV: if (m_hs) begin
                if (res_cnt != CW'(N - 1)) begin
                    res_n = res_cnt + CW'(1);
                end else if (frame_cnt == FW'(FRAMES - 1)) begin
                    state_n = FIN;
                end else begin
                    state_n = SEND;
                    frame_n = frame_cnt + FW'(1);
                    byte_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout) state_n = FIN;
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    end

    // counters, stall timer, outgoing byte register and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            byte_cnt  <= '0;
            res_cnt   <= '0;
            wait_cnt  <= '0;
            data_out  <= '0;
            err       <= 1'b0;
        end else begin
            frame_cnt <= frame_n;
            byte_cnt  <= byte_n;
            res_cnt   <= res_n;
            wait_cnt  <= (active && !s_hs && !m_hs) ? wait_cnt + 13'd1 : 13'd0;
            if (state_n == SEND) data_out <= stim_mem[rd_addr];
            err <= err || timeout || (m_valid && (state == SEND || state == IDLE));
        end
    end

    // stimulus memory accepts writes only while idle so a running replay stays consistent
    always_ff @(posedge clk) begin
        if (ld_we && state == IDLE) stim_mem[ld_addr] <= ld_data;
    end

    // capture each accepted result at its frame/result slot
    always_ff @(posedge clk) begin
        if (m_hs) res_buf[RW'(frame_cnt) * RW'(N) + RW'(res_cnt)] <= data_in;
    end
endmodule

// File: tb/tb_mvm_frame_driver.sv
// tb_mvm_frame_driver: randomized replay/capture checks against a queue-based core model
module tb_mvm_frame_driver;
    localparam int N = 3;
    localparam int FRAMES = 5;
    localparam int TOTAL = N * N + 2 * N;
    localparam int DEPTH = FRAMES * TOTAL;

    logic        clk = 1'b0;
    logic        reset_n, start, ld_we;
    logic [6:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        s_valid, s_ready;
    logic [7:0]  data_out;
    logic        m_valid, m_ready;
    logic [15:0] data_in;
    logic        rx_hold;
    logic [3:0]  res_addr;
    logic [15:0] res_data;
    logic        busy, done, err;

    mvm_frame_driver dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_data(ld_data), .s_valid(s_valid), .s_ready(s_ready),
        .data_out(data_out), .m_valid(m_valid), .m_ready(m_ready), .data_in(data_in),
        .rx_hold(rx_hold), .res_addr(res_addr), .res_data(res_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total_cnt = 0, bad_cnt = 0;
    int cyc = 0, rx_count, done_cnt, first_cyc, last_cyc, start_cyc;
    int pct_ready, pct_hold;
    bit fixed_res, poke_en, inj_en, start_req, prev_stall, after_last;
    logic [7:0]  prev_data;
    logic [7:0]  model_mem [DEPTH];
    logic [15:0] exp_res [FRAMES*N];
    logic [7:0]  exp_bytes [$];
    logic [15:0] res_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock of core-model behaviour: drive at negedge, observe the upcoming handshakes
    task automatic step();
        logic [7:0]  eb;
        logic [15:0] r;
        bit          poke_now;
        int          f;
        @(negedge clk);
        cyc++;
        poke_now = poke_en && busy && done_cnt == 0;
        start    = start_req || (poke_now && $urandom_range(3) == 0);
        ld_we    = poke_now && $urandom_range(3) == 0;
        ld_addr  = 7'($urandom_range(DEPTH - 1));
        ld_data  = ~model_mem[ld_addr];
        s_ready  = $urandom_range(99) < pct_ready;
        rx_hold  = $urandom_range(99) < pct_hold;
        if (res_q.size() > 0) begin
            m_valid = 1'b1;
            data_in = res_q[0];
        end else begin
            m_valid = inj_en && s_valid && rx_count == 20;
            data_in = 16'hDEAD;
        end
        #1;
        if (after_last) begin
            check("sv_after_frame", s_valid, 0);
            check("mr_after_frame", m_ready, !rx_hold);
            after_last = 0;
        end
        if (s_valid) check("mr_in_send", m_ready, 0);
        if (prev_stall && s_valid) check("stable", data_out, prev_data);
        prev_stall = s_valid && !s_ready;
        prev_data  = data_out;
        if (s_valid && s_ready) begin
            if (exp_bytes.size() > 0) eb = exp_bytes.pop_front();
            else eb = 8'hxx;
            check("byte", data_out, eb);
            check("serial", res_q.size(), 0);
            rx_count++;
            if (rx_count == 1) first_cyc = cyc;
            if (rx_count == TOTAL) begin
                last_cyc   = cyc;
                after_last = 1;
            end
            if (rx_count % TOTAL == 0) begin
                f = rx_count / TOTAL - 1;
                for (int i = 0; i < N; i++) begin
                    r = fixed_res ? 16'(16'h12 + 9 * i + 256 * f) : 16'($urandom);
                    if (f < FRAMES) exp_res[f*N+i] = r;
                    res_q.push_back(r);
                end
            end
        end
        if (m_valid && m_ready && res_q.size() > 0) r = res_q.pop_front();
        if (done) done_cnt++;
    endtask

    task automatic load(input bit f0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            model_mem[i] = (f0 && i < TOTAL) ? 8'(i + 1) : 8'($urandom);
            ld_we   = 1'b1;
            ld_addr = 7'(i);
            ld_data = model_mem[i];
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic start_run(input int pr, input int ph, input bit fx, input bit pk, input bit ij);
        pct_ready = pr;
        pct_hold  = ph;
        fixed_res = fx;
        poke_en   = pk;
        inj_en    = ij;
        rx_count  = 0;
        done_cnt  = 0;
        prev_stall = 0;
        after_last = 0;
        exp_bytes.delete();
        res_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_bytes.push_back(model_mem[i]);
        start_req = 1;
        step();
        start_req = 0;
        start_cyc = cyc;
    endtask

    task automatic finish_run(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 20000) begin
            step();
            n++;
        end
        repeat (3) step();
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_bytes"}, rx_count, DEPTH);
        check({tag, "_left"}, exp_bytes.size(), 0);
        check({tag, "_res_left"}, res_q.size(), 0);
        for (int i = 0; i < FRAMES * N; i++) begin
            res_addr = 4'(i);
            #1;
            check({tag, "_res"}, res_data, exp_res[i]);
        end
    endtask

    initial begin
        int n;
        reset_n = 1'b0; start = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        s_ready = 1'b0; m_valid = 1'b0; data_in = '0; rx_hold = 1'b0; res_addr = '0;
        start_req = 0; poke_en = 0; inj_en = 0; pct_ready = 0; pct_hold = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_sv", s_valid, 0);
        check("rst_mr", m_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_data", data_out, 0);
        reset_n = 1'b1;

        load(1);
        start_run(100, 0, 1, 0, 0);
        finish_run("t1");
        check("t1_latency", first_cyc - start_cyc, 1);
        check("t1_burst", last_cyc - first_cyc, TOTAL - 1);
        check("t1_err", err, 0);
        res_addr = 4'd0; #1; check("t2_res0", res_data, 16'h0012);
        res_addr = 4'd1; #1; check("t2_res1", res_data, 16'h001B);
        res_addr = 4'd2; #1; check("t2_res2", res_data, 16'h0024);

        load(0);
        start_run(50, 50, 0, 0, 0);
        finish_run("t3");
        check("t3_err", err, 0);

        start_run(50, 50, 0, 1, 0);
        finish_run("t4");
        check("t4_err", err, 0);

        start_run(70, 30, 0, 0, 1);
        finish_run("t5");
        check("t5_err", err, 1);
        repeat (5) step();
        check("t5_sticky", err, 1);

        start_run(60, 0, 0, 0, 0);
        n = 0;
        while (rx_count < 3 * TOTAL && n < 5000) begin
            step();
            n++;
        end
        step();
        check("t6_recv_mr", m_ready, 1);
        check("t6_recv_sv", s_valid, 0);
        reset_n = 1'b0;
        #1;
        check("t6_rst_sv", s_valid, 0);
        check("t6_rst_mr", m_ready, 0);
        check("t6_rst_busy", busy, 0);
        m_valid = 1'b0;
        res_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("t6_err_clr", err, 0);
        start_run(50, 50, 0, 0, 0);
        finish_run("t6_replay");
        check("t6_err", err, 0);

        start_run(0, 0, 0, 0, 0);
        n = 0;
        while (done_cnt == 0 && n < 6000) begin
            step();
            n++;
        end
        check("to_cycles", n, 4098);
        check("to_err", err, 1);
        check("to_bytes", rx_count, 0);
        step();
        check("to_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
